// File: rtl/mmc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmc_pkg
// Description : Shared types and constants for the LCM engine scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package mmc_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    // Bits needed to encode a number of distinct codes
    function automatic int err_width(input int n_codes);
        return (n_codes > 1) ? $clog2(n_codes) : 1;
    endfunction

    localparam int ERR_W = err_width(3);

    localparam logic [ERR_W-1:0] ERR_OK      = ERR_W'(0);
    localparam logic [ERR_W-1:0] ERR_ZERO    = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = ERR_W'(2);

endpackage
`default_nettype wire

// File: rtl/mmc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mmc_ctrl_if
// Description : Requester, response and engine signals of the LCM scheduler.
//               slave = scheduler view, master = environment view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mmc_ctrl_if
    import mmc_pkg::*;
#(
    parameter int N   = 4,
    parameter int W   = 32,
    parameter int IDW = $clog2(N)
);
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [W-1:0]     rsp_res;
    logic [ERR_W-1:0] rsp_err;
    logic             eng_ld;
    logic [W-1:0]     eng_a;
    logic [W-1:0]     eng_b;
    logic [W-1:0]     eng_res;
    logic             eng_done;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, eng_res, eng_done,
        output req_ready, rsp_valid, rsp_id, rsp_res, rsp_err, eng_ld, eng_a, eng_b
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, eng_res, eng_done,
        input  req_ready, rsp_valid, rsp_id, rsp_res, rsp_err, eng_ld, eng_a, eng_b
    );

endinterface
`default_nettype wire

// File: rtl/mmc_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : mmc_rr_arb
// Description : Combinational round-robin picker. Searches upward from
//               ptr+1 with wrap; the pointer register lives in the caller.
// Revision    : 1.0 - initial release
// ============================================================================
module mmc_rr_arb #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  wire logic [N-1:0]   req_i,
    input  wire logic [IDW-1:0] ptr_i,
    input  wire logic           en_i,
    output logic      [N-1:0]   gnt_o,
    output logic      [IDW-1:0] gnt_id_o,
    output logic                any_o
);

    logic [IDW-1:0] w_idx;
    logic           w_found;

    // First set request after the pointer, wrapping around
    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int i = 1; i <= N; i++) begin
            w_idx = IDW'((int'(ptr_i) + i) % N);
            if (!w_found && req_i[w_idx]) begin
                w_found  = 1'b1;
                gnt_id_o = w_idx;
            end
        end
        any_o = en_i & w_found;
        if (any_o) begin
            gnt_o[gnt_id_o] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mmc_ctrl
// Description : Shares one external iterative LCM engine among N requesters:
//               round-robin grant, zero-operand screening, engine load with
//               iteration timeout, tagged valid/ready response.
// Revision    : 1.0 - initial release
// ============================================================================
module mmc_ctrl
    import mmc_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 32,
    parameter int MAX_ITER = 1024,
    parameter int IDW      = $clog2(N)
) (
    input  wire logic clk,
    input  wire logic rst_n,
    mmc_ctrl_if.slave bus
);

    localparam int               CNT_W    = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_ITER - 1);

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             eng_ld_q, eng_ld_d;
    logic [W-1:0]     eng_a_q, eng_a_d;
    logic [W-1:0]     eng_b_q, eng_b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [W-1:0]     rsp_res_q, rsp_res_d;
    logic [ERR_W-1:0] rsp_err_q, rsp_err_d;

    logic [N-1:0]     w_gnt;
    logic [IDW-1:0]   w_gnt_id;
    logic             w_any;
    logic             w_arb_en;
    logic [W-1:0]     w_sel_a;
    logic [W-1:0]     w_sel_b;

    // Grants only from IDLE; held off while reset is asserted so the
    // accept strobe is low together with every registered output.
    assign w_arb_en = (state_q == IDLE) && rst_n;

    mmc_rr_arb #(
        .N   (N),
        .IDW (IDW)
    ) u_arb (
        .req_i    (bus.req_valid),
        .ptr_i    (ptr_q),
        .en_i     (w_arb_en),
        .gnt_o    (w_gnt),
        .gnt_id_o (w_gnt_id),
        .any_o    (w_any)
    );

    assign w_sel_a = bus.req_a[int'(w_gnt_id)*W +: W];
    assign w_sel_b = bus.req_b[int'(w_gnt_id)*W +: W];

    assign bus.req_ready = w_gnt;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_res   = rsp_res_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.eng_ld    = eng_ld_q;
    assign bus.eng_a     = eng_a_q;
    assign bus.eng_b     = eng_b_q;

    // Next-state and registered-output decode for the scheduler
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        eng_ld_d    = 1'b0;
        eng_a_d     = eng_a_q;
        eng_b_d     = eng_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_res_d   = rsp_res_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (w_any) begin
                    ptr_d    = w_gnt_id;
                    rsp_id_d = w_gnt_id;
                    eng_a_d  = w_sel_a;
                    eng_b_d  = w_sel_b;
                    // A zero operand would never converge in the engine
                    if ((w_sel_a == '0) || (w_sel_b == '0)) begin
                        rsp_valid_d = 1'b1;
                        rsp_res_d   = '0;
                        rsp_err_d   = ERR_ZERO;
                        state_d     = RESP;
                    end else begin
                        eng_ld_d = 1'b1;
                        state_d  = LOAD;
                    end
                end
            end
            LOAD: begin
                // eng_done is stale here and deliberately ignored
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (bus.eng_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_res_d   = bus.eng_res;
                    rsp_err_d   = ERR_OK;
                    state_d     = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_res_d   = '0;
                    rsp_err_d   = ERR_TIMEOUT;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; pointer resets to N-1 so requester 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= IDW'(N - 1);
            cnt_q       <= '0;
            eng_ld_q    <= 1'b0;
            eng_a_q     <= '0;
            eng_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_res_q   <= '0;
            rsp_err_q   <= ERR_OK;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            eng_ld_q    <= eng_ld_d;
            eng_a_q     <= eng_a_d;
            eng_b_q     <= eng_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_res_q   <= rsp_res_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule
`default_nettype wire
